dm_cache_wt: RTL and testbench
==============================

// Module: dm_cache_wt
// PURPOSE
//  Parametrised direct-mapped, write-through, read-allocate data cache between CPU load/store port and
//  data memory. Next generation of the fixed 1024x4-word cache: adds miss handling (refill FSM with
//  memory handshake), CPU stall signalling, write-through to memory and hit/miss counters.
// PARAMETERS
//  ADDR_W          15    word address width (CPU and memory)
//  WORD_W          32    data word width
//  WORDS_PER_LINE  4     words per line, power of 2, >=2
//  LINES           1024  number of lines, power of 2
//  CNT_W           16    width of hit/miss counters
//  derived: OFF_W=clog2(WORDS_PER_LINE), IDX_W=clog2(LINES), TAG_W=ADDR_W-IDX_W-OFF_W (default 2/10/3)
// PORTS
//  clk         in   1                  clock, all state on rising edge
//  rst         in   1                  asynchronous reset, active-high
//  cpu_read    in   1                  load request, held until cpu_ready
//  cpu_write   in   1                  store request, held until cpu_ready
//  cpu_addr    in   ADDR_W             word address {tag,index,offset}
//  cpu_wdata   in   WORD_W             store data
//  cpu_rdata   out  WORD_W             load data, valid when cpu_ready & cpu_read
//  cpu_ready   out  1                  request completes this cycle; low = stall
//  hit         out  1                  combinational: valid[index] & tag match
//  mem_req     out  1                  memory request, held until mem_ack
//  mem_we      out  1                  1=word write, 0=line read
//  mem_addr    out  ADDR_W             read: line addr (offset=0); write: cpu_addr
//  mem_wdata   out  WORD_W             = cpu_wdata
//  mem_ack     in   1                  memory completes request this cycle
//  mem_rdata   in   WORD_W*WORDS_PER_LINE  refill line, word0 in LSBs, valid with mem_ack
//  hit_count   out  CNT_W              saturating count of read hits
//  miss_count  out  CNT_W              saturating count of read misses
// BEHAVIOUR
//  Reset: all valid bits 0, state IDLE, counters 0, cpu_ready=0, mem_req=0, mem_we=0. Tag/data arrays not reset.
//  States: IDLE, REFILL, WRITE_MEM.
//  IDLE: cpu_write (priority over cpu_read if both high) -> WRITE_MEM, cpu_ready=0.
//        cpu_read & hit -> cpu_ready=1, cpu_rdata=line[offset] same cycle, hit_count++; stay IDLE.
//        cpu_read & ~hit -> cpu_ready=0, miss_count++ (once per miss), -> REFILL.
//        no request -> cpu_ready=0, mem_req=0.
//  REFILL: mem_req=1, mem_we=0, mem_addr={tag,index,OFF_W'0}. On mem_ack: store mem_rdata, tag, valid=1
//        at index; -> IDLE. Next cycle the held read hits (counts as hit too). Read miss latency = ack + 1 cycle.
//  WRITE_MEM: mem_req=1, mem_we=1, mem_addr=cpu_addr. On mem_ack: cpu_ready=1; if hit, word at offset
//        updated in same edge (no allocate on write miss; valid/tag unchanged); -> IDLE.
//  mem_req deasserts the cycle after ack (registered state); memory must not ack when mem_req=0.
//  Counters saturate at all-ones; no wrap.
//  cpu_rdata outside cpu_ready&cpu_read: don't care; must not be X in sim after valid refill.
//  Reset mid-REFILL/WRITE_MEM: request abandoned immediately (mem_req=0 async), no array update,
//        valid cleared; memory must tolerate abandoned request.
//  Request inputs changing before cpu_ready: protocol violation, behaviour undefined (assert in bench).
// STRUCTURE
//  Package cache_pkg: state enum (IDLE/REFILL/WRITE_MEM), clog2-based localparam helpers for OFF_W/IDX_W/TAG_W.
//  Sub-module cache_line_store: tag+data arrays (LINES entries), 1 comb read port, 1 write port with
//  full-line or single-word-enable write; valid vector and FSM stay in dm_cache_wt.
// TESTING
//  1. Reset, read 0x0123 -> miss, REFILL mem_addr=0x0120; ack line {D,C,B,A} -> next cycle cpu_ready, rdata=D (offset 3).
//  2. Read 0x0120 after test 1 -> same-cycle cpu_ready, rdata=A, hit_count=2, miss_count=1, no mem_req.
//  3. Write 0x0121 data 0xDEADBEEF (hit) -> mem_we=1, mem_addr=0x0121; after ack, read 0x0121 hits = 0xDEADBEEF.
//  4. Write 0x1121 (same index, other tag, miss) -> memory written, line at index 0x048 unchanged; read 0x0121 still hits.
//  5. Conflict: read 0x0120 then 0x2120 -> second evicts first; re-read 0x0120 misses (miss_count+1).
//  6. Assert rst during REFILL before ack -> mem_req drops, valid cleared; post-reset read of same addr misses; counter saturation with CNT_W=2 stops at 3.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through cache.
package cache_pkg;

  // Controller states: idle/lookup, line refill from memory, word write-through.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    WRITE_MEM = 2'd2
  } state_e;

  // Word-offset width within a line.
  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Line-index width.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: whatever address bits remain above index and offset.
  function automatic int tag_w(input int addr_w, input int words_per_line, input int lines);
    return addr_w - $clog2(words_per_line) - $clog2(lines);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag and data arrays of the cache: one combinational read port and one write
// port that either replaces a whole line (with its tag) or a single word.
// Contents are deliberately not reset; validity is tracked by the controller.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int IDX_W          = 10,
  parameter int TAG_W          = 3,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                             i_clk,
  input  logic [IDX_W-1:0]                 i_rd_idx,
  output logic [TAG_W-1:0]                 o_rd_tag,
  output logic [WORD_W*WORDS_PER_LINE-1:0] o_rd_line,
  input  logic [IDX_W-1:0]                 i_wr_idx,
  input  logic                             i_wr_line_en,
  input  logic [TAG_W-1:0]                 i_wr_tag,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] i_wr_line,
  input  logic                             i_wr_word_en,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] i_wr_off,
  input  logic [WORD_W-1:0]                i_wr_word
);

  localparam int LINES  = 2 ** IDX_W;
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  logic [TAG_W-1:0]  r_tag_mem  [LINES];
  logic [LINE_W-1:0] r_data_mem [LINES];

  assign o_rd_tag  = r_tag_mem[i_rd_idx];
  assign o_rd_line = r_data_mem[i_rd_idx];

  // Array update: a full-line refill takes precedence over a single-word store.
  always_ff @(posedge i_clk) begin
    if (i_wr_line_en) begin
      r_tag_mem[i_wr_idx]  <= i_wr_tag;
      r_data_mem[i_wr_idx] <= i_wr_line;
    end else if (i_wr_word_en) begin
      r_data_mem[i_wr_idx][i_wr_off*WORD_W +: WORD_W] <= i_wr_word;
    end
  end

endmodule

// File: rtl/dm_cache_wt.sv
// Direct-mapped, write-through, read-allocate data cache. Read hits complete in
// the request cycle; read misses refill a whole line and then hit; every store
// is forwarded to memory and only updates the cached copy when the line is present.
module dm_cache_wt
  import cache_pkg::*;
#(
  parameter int ADDR_W         = 15,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_read,
  input  logic                             cpu_write,
  input  logic [ADDR_W-1:0]                cpu_addr,
  input  logic [WORD_W-1:0]                cpu_wdata,
  output logic [WORD_W-1:0]                cpu_rdata,
  output logic                             cpu_ready,
  output logic                             hit,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [WORD_W-1:0]                mem_wdata,
  input  logic                             mem_ack,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_rdata,
  output logic [CNT_W-1:0]                 hit_count,
  output logic [CNT_W-1:0]                 miss_count
);

  localparam int OFF_W  = off_w(WORDS_PER_LINE);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, WORDS_PER_LINE, LINES);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Address fields of the (held) CPU request.
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [LINE_W-1:0] w_rd_line;
  logic              w_hit;
  logic              w_we_line;
  logic              w_we_word;
  logic              w_cpu_ready;

  state_e            r_state;
  logic [LINES-1:0]  r_valid;
  logic [CNT_W-1:0]  r_hit_count;
  logic [CNT_W-1:0]  r_miss_count;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;

  assign w_tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_idx = cpu_addr[OFF_W +: IDX_W];
  assign w_off = cpu_addr[OFF_W-1:0];

  assign w_hit = r_valid[w_idx] & (w_rd_tag == w_tag);

  // The refill lands on the ack edge; a store only touches a line that is present.
  assign w_we_line = (r_state == REFILL) & mem_ack;
  assign w_we_word = (r_state == WRITE_MEM) & mem_ack & w_hit;

  cache_line_store #(
    .IDX_W          (IDX_W),
    .TAG_W          (TAG_W),
    .WORD_W         (WORD_W),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_store (
    .i_clk        (clk),
    .i_rd_idx     (w_idx),
    .o_rd_tag     (w_rd_tag),
    .o_rd_line    (w_rd_line),
    .i_wr_idx     (w_idx),
    .i_wr_line_en (w_we_line),
    .i_wr_tag     (w_tag),
    .i_wr_line    (mem_rdata),
    .i_wr_word_en (w_we_word),
    .i_wr_off     (w_off),
    .i_wr_word    (cpu_wdata)
  );

  // Completion: read hits finish in the request cycle, stores on the memory ack.
  always_comb begin
    w_cpu_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_read & ~cpu_write & w_hit) begin
          w_cpu_ready = 1'b1;
        end else begin
          w_cpu_ready = 1'b0;
        end
      end
      WRITE_MEM: begin
        if (mem_ack) begin
          w_cpu_ready = 1'b1;
        end else begin
          w_cpu_ready = 1'b0;
        end
      end
      default: w_cpu_ready = 1'b0;
    endcase
  end

  // Controller: lookup, refill and write-through sequencing, valid bits and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_valid      <= {LINES{1'b0}};
      r_hit_count  <= {CNT_W{1'b0}};
      r_miss_count <= {CNT_W{1'b0}};
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_write) begin
            r_state    <= WRITE_MEM;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b1;
            r_mem_addr <= cpu_addr;
          end else if (cpu_read) begin
            if (w_hit) begin
              if (r_hit_count != CNT_MAX) begin
                r_hit_count <= r_hit_count + CNT_ONE;
              end
            end else begin
              if (r_miss_count != CNT_MAX) begin
                r_miss_count <= r_miss_count + CNT_ONE;
              end
              r_state    <= REFILL;
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
            end
          end else begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            r_valid[w_idx] <= 1'b1;
            r_state        <= IDLE;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
          end
        end
        WRITE_MEM: begin
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rdata  = w_rd_line[w_off*WORD_W +: WORD_W];
  assign cpu_ready  = w_cpu_ready;
  assign hit        = w_hit;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = cpu_wdata;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_dm_cache_wt.sv
// Randomised scoreboard bench for dm_cache_wt. The reference model treats the
// cache as transparent over a word memory: loads always return memory contents,
// and only hit/miss (hence latency, memory traffic and counters) depends on a
// per-index valid/tag table. A second instance with 2-bit counters checks saturation.
module tb_dm_cache_wt;

  localparam int ADDR_W = 15;
  localparam int WORD_W = 32;
  localparam int WPL    = 4;
  localparam int LINES  = 1024;
  localparam int CNT_W  = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cpu_read = 1'b0;
  logic                  cpu_write = 1'b0;
  logic [ADDR_W-1:0]     cpu_addr = '0;
  logic [WORD_W-1:0]     cpu_wdata = '0;
  logic                  mem_ack;
  logic [WORD_W*WPL-1:0] mem_rdata;

  logic [WORD_W-1:0] cpu_rdata, s_cpu_rdata;
  logic              cpu_ready, s_cpu_ready, hit, s_hit;
  logic              mem_req, s_mem_req, mem_we, s_mem_we;
  logic [ADDR_W-1:0] mem_addr, s_mem_addr;
  logic [WORD_W-1:0] mem_wdata, s_mem_wdata;
  logic [CNT_W-1:0]  hit_count, miss_count;
  logic [1:0]        s_hit_count, s_miss_count;

  dm_cache_wt #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .LINES(LINES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count));

  dm_cache_wt #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .LINES(LINES), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(s_cpu_rdata), .cpu_ready(s_cpu_ready), .hit(s_hit),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(s_hit_count), .miss_count(s_miss_count));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { bit is_read; logic [WORD_W-1:0] rdata; } cpu_exp_t;
  typedef struct { bit we; logic [ADDR_W-1:0] addr; logic [WORD_W-1:0] wdata; } mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  bit no_ack = 1'b0;

  // Reference model state
  bit                m_valid [LINES];
  int unsigned       m_tag   [LINES];
  int unsigned       m_hits = 0;
  int unsigned       m_misses = 0;
  logic [WORD_W-1:0] mem_model [int unsigned];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] mem_rd(input int unsigned a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h5A5A_0000 ^ (a * 32'h0001_0193);
  endfunction

  function automatic int unsigned sat3(input int unsigned v);
    return (v > 3) ? 3 : v;
  endfunction

  // CPU-side monitor: every completion pops one expected response.
  always @(negedge clk) begin
    cpu_exp_t e;
    if (!rst && cpu_ready) begin
      if (cpu_q.size() == 0) begin
        chk("cpu_ready_unexpected", 64'd1, 64'd0);
      end else begin
        e = cpu_q.pop_front();
        chk("sat_ready_match", s_cpu_ready, 1'b1);
        if (e.is_read) begin
          chk("rdata", cpu_rdata, e.rdata);
          chk("sat_rdata", s_cpu_rdata, e.rdata);
        end
      end
    end
  end

  // Memory responder: checks each request against the expected traffic, acks after a random delay.
  initial begin
    mem_exp_t m;
    int dly;
    bit aborted;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && mem_req) begin
        if (mem_q.size() == 0) begin
          chk("mem_req_unexpected", 64'd1, 64'd0);
          m.we = mem_we; m.addr = mem_addr; m.wdata = mem_wdata;
        end else begin
          m = mem_q.pop_front();
          chk("mem_we", mem_we, m.we);
          chk("mem_addr", mem_addr, m.addr);
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
          chk("sat_mem_req", s_mem_req, 1'b1);
        end
        dly = no_ack ? 200 : $urandom_range(0, 3);
        aborted = 1'b0;
        for (int k = 0; k < dly; k++) begin
          @(posedge clk); #1;
          if (rst) begin aborted = 1'b1; break; end
          chk("mem_req_hold", mem_req, 1'b1);
        end
        if (no_ack && !aborted) chk("abandon_timeout", 64'd1, 64'd0);
        if (!aborted) begin
          for (int w = 0; w < WPL; w++)
            mem_rdata[w*WORD_W +: WORD_W] = mem_rd((int'(m.addr) & ~3) + w);
          mem_ack = 1'b1;
          #1;
          if (m.we) chk("wr_ready_on_ack", cpu_ready, 1'b1);
          @(posedge clk); #1;
          mem_ack = 1'b0;
          chk("mem_req_drop", mem_req, 1'b0);
          if (!m.we) chk("refill_then_hit", cpu_ready, 1'b1);
        end
      end
    end
  end

  // Issue one request, record expectations, wait (bounded) for completion, check counters.
  task automatic do_req(input bit rd, input bit wr, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    int unsigned idx = a[11:2];
    int unsigned tg  = a[14:12];
    bit exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    int cyc = 0;
    bit done = 1'b0;
    if (wr) begin
      mem_q.push_back('{1'b1, a, d});
      cpu_q.push_back('{1'b0, 32'h0});
      mem_model[a] = d;
    end else begin
      if (!exp_hit) begin
        mem_q.push_back('{1'b0, {a[14:2], 2'b00}, 32'h0});
        m_misses++;
        m_valid[idx] = 1'b1;
        m_tag[idx] = tg;
      end
      m_hits++;
      cpu_q.push_back('{1'b1, mem_rd(a)});
    end
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("hit_flag", hit, exp_hit);
        chk("first_cycle_ready", cpu_ready, rd && !wr && exp_hit);
      end
      if (cpu_ready) done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("req_timeout", 64'd0, 64'd1);
    cpu_read = 1'b0; cpu_write = 1'b0;
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
    chk("sat_hit_count", s_hit_count, sat3(m_hits));
    chk("sat_miss_count", s_miss_count, sat3(m_misses));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [2:0] tg;
    logic [9:0] idx;
    logic [1:0] off;
    logic [9:0] idx_set [4];
    idx_set[0] = 10'h048; idx_set[1] = 10'h049; idx_set[2] = 10'h3FF; idx_set[3] = 10'h000;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_hit_count", hit_count, 16'd0);
    chk("rst_miss_count", miss_count, 16'd0);
    @(posedge clk); #1;

    // Directed: refill, hit, store hit, store miss, conflict eviction
    mem_model[32'h120] = 32'hAAAA_0001;
    mem_model[32'h121] = 32'hBBBB_0002;
    mem_model[32'h122] = 32'hCCCC_0003;
    mem_model[32'h123] = 32'hDDDD_0004;
    do_req(1'b1, 1'b0, 15'h0123, 32'h0);
    do_req(1'b1, 1'b0, 15'h0120, 32'h0);
    chk("t2_hit_count", hit_count, 16'd2);
    chk("t2_miss_count", miss_count, 16'd1);
    do_req(1'b0, 1'b1, 15'h0121, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 15'h0121, 32'h0);
    do_req(1'b0, 1'b1, 15'h1121, 32'hCAFE_F00D);
    do_req(1'b1, 1'b0, 15'h0121, 32'h0);
    do_req(1'b1, 1'b0, 15'h0123, 32'h0);
    do_req(1'b1, 1'b0, 15'h0120, 32'h0);
    do_req(1'b1, 1'b0, 15'h2120, 32'h0);
    do_req(1'b1, 1'b0, 15'h0120, 32'h0);
    do_req(1'b1, 1'b0, 15'h1121, 32'h0);

    // Random mix over a few colliding indices
    for (int n = 0; n < 250; n++) begin
      tg  = 3'($urandom_range(0, 7));
      idx = idx_set[$urandom_range(0, 3)];
      off = 2'($urandom_range(0, 3));
      a = {tg, idx, off};
      if ($urandom_range(0, 9) < 6) do_req(1'b1, 1'b0, a, $urandom);
      else do_req(($urandom_range(0, 3) == 0), 1'b1, a, $urandom);
    end

    // Reset while a refill is outstanding
    a = 15'h7ABD;
    mem_q.push_back('{1'b0, 15'h7ABC, 32'h0});
    no_ack = 1'b1;
    cpu_read = 1'b1; cpu_addr = a;
    repeat (4) @(posedge clk);
    #1 chk("pre_rst_mem_req", mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_mem_req_drop", mem_req, 1'b0);
    chk("async_sat_mem_req_drop", s_mem_req, 1'b0);
    chk("rst_ready_low", cpu_ready, 1'b0);
    cpu_read = 1'b0;
    no_ack = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits = 0; m_misses = 0;
    repeat (2) @(posedge clk);
    #1 chk("rst_counts_cleared", {hit_count, miss_count}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, a, 32'h0);
    chk("post_rst_miss", miss_count, 16'd1);
    do_req(1'b1, 1'b0, 15'h0120, 32'h0);

    // Push the 2-bit counters past their ceiling
    for (int n = 0; n < 6; n++) do_req(1'b1, 1'b0, 15'h0122, 32'h0);
    for (int n = 0; n < 3; n++) do_req(1'b1, 1'b0, {3'(n + 1), 12'h5A4}, 32'h0);
    chk("sat_hit_ceiling", s_hit_count, 2'd3);
    chk("sat_miss_ceiling", s_miss_count, 2'd3);

    repeat (4) @(posedge clk);
    #1;
    chk("mem_q_drained", mem_q.size(), 0);
    chk("cpu_q_drained", cpu_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
